// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel filter: valid/ready window in, saturated edge value out.
// Three lock-step pipeline stages with internal row/column tracking and border forcing.
module sobel_stream #(
   parameter int          PIX_W      = 8,
   parameter int          MAX_ROW    = 480,
   parameter int          MAX_COL    = 640,
   parameter int unsigned BORDER_VAL = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sof,
   input  logic [8*PIX_W-1:0] window,
   input  logic [1:0]         mode,
   input  logic [PIX_W-1:0]   threshold,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PIX_W-1:0]   out_pixel,
   output logic               out_sof,
   output logic               out_eof,
   output logic               sof_err
);

   localparam int GW = PIX_W + 3;
   localparam int RW = $clog2(MAX_ROW);
   localparam int CW = $clog2(MAX_COL);

   localparam logic [RW-1:0]    ROW_LAST = RW'(MAX_ROW - 1);
   localparam logic [CW-1:0]    COL_LAST = CW'(MAX_COL - 1);
   localparam logic [PIX_W-1:0] PIX_MAX  = '1;
   localparam logic [PIX_W-1:0] THR_RST  = {1'b1, {(PIX_W-1){1'b0}}};
   localparam logic [PIX_W-1:0] BVAL     = PIX_W'(BORDER_VAL);

   function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
      return $signed({3'b000, p});
   endfunction

   function automatic logic [PIX_W-1:0] sat(input logic [GW-1:0] x);
      return (x > GW'(PIX_MAX)) ? PIX_MAX : x[PIX_W-1:0];
   endfunction

   logic [PIX_W-1:0] tl, tc, tr, ml, mr, bl, bc, br;
   assign {tl, tc, tr, ml, mr, bl, bc, br} = window;

   logic adv, acc;

   logic [RW-1:0]    row_q, row_d, pos_row;
   logic [CW-1:0]    col_q, col_d, pos_col;
   logic [1:0]       cfg_mode_q, cfg_mode_d, eff_mode;
   logic [PIX_W-1:0] cfg_thr_q, cfg_thr_d, eff_thr;
   logic             sof_err_q, sof_err_d;

   logic                 s1_vld_q, s1_vld_d;
   logic signed [GW-1:0] s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
   logic                 s1_bdr_q, s1_bdr_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
   logic [1:0]           s1_mode_q, s1_mode_d;
   logic [PIX_W-1:0]     s1_thr_q, s1_thr_d;

   logic             s2_vld_q, s2_vld_d;
   logic [GW-1:0]    s2_ax_q, s2_ax_d, s2_ay_q, s2_ay_d, s2_sum_q, s2_sum_d;
   logic             s2_bdr_q, s2_bdr_d, s2_sof_q, s2_sof_d, s2_eof_q, s2_eof_d;
   logic [1:0]       s2_mode_q, s2_mode_d;
   logic [PIX_W-1:0] s2_thr_q, s2_thr_d;

   logic             out_vld_q, out_vld_d;
   logic [PIX_W-1:0] out_pix_q, out_pix_d, sat_sum;
   logic             out_sof_q, out_sof_d, out_eof_q, out_eof_d;

   assign adv      = out_ready || !out_vld_q;
   assign in_ready = adv;
   assign acc      = in_valid && adv;

   // A frame start overrides the tracked position and the latched config.
   assign pos_row  = in_sof ? '0 : row_q;
   assign pos_col  = in_sof ? '0 : col_q;
   assign eff_mode = in_sof ? mode : cfg_mode_q;
   assign eff_thr  = in_sof ? threshold : cfg_thr_q;
   assign sat_sum  = sat(s2_sum_q);

   always_comb begin
      row_d      = row_q;
      col_d      = col_q;
      cfg_mode_d = cfg_mode_q;
      cfg_thr_d  = cfg_thr_q;
      sof_err_d  = acc && in_sof && (row_q != '0 || col_q != '0);
      if (acc) begin
         if (pos_col == COL_LAST) begin
            col_d = '0;
            row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
         end else begin
            col_d = pos_col + CW'(1);
            row_d = pos_row;
         end
         if (in_sof) begin
            cfg_mode_d = mode;
            cfg_thr_d  = threshold;
         end
      end
   end

   always_comb begin
      s1_vld_d  = s1_vld_q;
      s1_gx_d   = s1_gx_q;
      s1_gy_d   = s1_gy_q;
      s1_bdr_d  = s1_bdr_q;
      s1_sof_d  = s1_sof_q;
      s1_eof_d  = s1_eof_q;
      s1_mode_d = s1_mode_q;
      s1_thr_d  = s1_thr_q;
      if (adv) begin
         s1_vld_d  = acc;
         s1_gx_d   = ext(tr) - ext(tl) + (ext(mr) <<< 1) - (ext(ml) <<< 1)
                   + ext(br) - ext(bl);
         s1_gy_d   = ext(bl) + (ext(bc) <<< 1) + ext(br) - ext(tl)
                   - (ext(tc) <<< 1) - ext(tr);
         s1_bdr_d  = (pos_row == '0) || (pos_row == ROW_LAST)
                  || (pos_col == '0) || (pos_col == COL_LAST);
         s1_sof_d  = (pos_row == '0) && (pos_col == '0);
         s1_eof_d  = (pos_row == ROW_LAST) && (pos_col == COL_LAST);
         s1_mode_d = eff_mode;
         s1_thr_d  = eff_thr;
      end
   end

   always_comb begin
      s2_vld_d  = s2_vld_q;
      s2_ax_d   = s2_ax_q;
      s2_ay_d   = s2_ay_q;
      s2_sum_d  = s2_sum_q;
      s2_bdr_d  = s2_bdr_q;
      s2_sof_d  = s2_sof_q;
      s2_eof_d  = s2_eof_q;
      s2_mode_d = s2_mode_q;
      s2_thr_d  = s2_thr_q;
      if (adv) begin
         s2_vld_d  = s1_vld_q;
         s2_ax_d   = s1_gx_q[GW-1] ? $unsigned(-s1_gx_q) : $unsigned(s1_gx_q);
         s2_ay_d   = s1_gy_q[GW-1] ? $unsigned(-s1_gy_q) : $unsigned(s1_gy_q);
         s2_sum_d  = s2_ax_d + s2_ay_d;
         s2_bdr_d  = s1_bdr_q;
         s2_sof_d  = s1_sof_q;
         s2_eof_d  = s1_eof_q;
         s2_mode_d = s1_mode_q;
         s2_thr_d  = s1_thr_q;
      end
   end

   always_comb begin
      out_vld_d = out_vld_q;
      out_pix_d = out_pix_q;
      out_sof_d = out_sof_q;
      out_eof_d = out_eof_q;
      if (adv) begin
         out_vld_d = s2_vld_q;
         out_sof_d = s2_sof_q;
         out_eof_d = s2_eof_q;
         case (s2_mode_q)
            2'd0:    out_pix_d = sat_sum;
            2'd1:    out_pix_d = (sat_sum >= s2_thr_q) ? PIX_MAX : '0;
            2'd2:    out_pix_d = sat(s2_ax_q);
            default: out_pix_d = sat(s2_ay_q);
         endcase
         if (s2_bdr_q) out_pix_d = BVAL;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         row_q      <= '0;
         col_q      <= '0;
         cfg_mode_q <= 2'd1;
         cfg_thr_q  <= THR_RST;
         sof_err_q  <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_gx_q    <= '0;
         s1_gy_q    <= '0;
         s1_bdr_q   <= 1'b0;
         s1_sof_q   <= 1'b0;
         s1_eof_q   <= 1'b0;
         s1_mode_q  <= '0;
         s1_thr_q   <= '0;
         s2_vld_q   <= 1'b0;
         s2_ax_q    <= '0;
         s2_ay_q    <= '0;
         s2_sum_q   <= '0;
         s2_bdr_q   <= 1'b0;
         s2_sof_q   <= 1'b0;
         s2_eof_q   <= 1'b0;
         s2_mode_q  <= '0;
         s2_thr_q   <= '0;
         out_vld_q  <= 1'b0;
         out_pix_q  <= '0;
         out_sof_q  <= 1'b0;
         out_eof_q  <= 1'b0;
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         cfg_mode_q <= cfg_mode_d;
         cfg_thr_q  <= cfg_thr_d;
         sof_err_q  <= sof_err_d;
         s1_vld_q   <= s1_vld_d;
         s1_gx_q    <= s1_gx_d;
         s1_gy_q    <= s1_gy_d;
         s1_bdr_q   <= s1_bdr_d;
         s1_sof_q   <= s1_sof_d;
         s1_eof_q   <= s1_eof_d;
         s1_mode_q  <= s1_mode_d;
         s1_thr_q   <= s1_thr_d;
         s2_vld_q   <= s2_vld_d;
         s2_ax_q    <= s2_ax_d;
         s2_ay_q    <= s2_ay_d;
         s2_sum_q   <= s2_sum_d;
         s2_bdr_q   <= s2_bdr_d;
         s2_sof_q   <= s2_sof_d;
         s2_eof_q   <= s2_eof_d;
         s2_mode_q  <= s2_mode_d;
         s2_thr_q   <= s2_thr_d;
         out_vld_q  <= out_vld_d;
         out_pix_q  <= out_pix_d;
         out_sof_q  <= out_sof_d;
         out_eof_q  <= out_eof_d;
      end
   end

   assign out_valid = out_vld_q;
   assign out_pixel = out_pix_q;
   assign out_sof   = out_vld_q && out_sof_q;
   assign out_eof   = out_vld_q && out_eof_q;
   assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream on a reduced 8x20 image.
// Expected pixels come from a behavioural Sobel model of each accepted window.
module tb_sobel_stream;

   localparam int NR = 8;
   localparam int NC = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic        in_sof;
   logic [63:0] window;
   logic [1:0]  mode;
   logic [7:0]  threshold;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_pixel;
   logic        out_sof;
   logic        out_eof;
   logic        sof_err;

   sobel_stream #(
      .PIX_W(8), .MAX_ROW(NR), .MAX_COL(NC), .BORDER_VAL(0)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .window(window), .mode(mode), .threshold(threshold),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_sof(out_sof), .out_eof(out_eof), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int pix;
      int sof;
      int eof;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   int   err_at = -10;
   int   first_acc = -1;
   int   m_row = 0, m_col = 0, m_mode = 1, m_thr = 128;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [63:0] mkwin(input int tl, t, tr, ml, mr, bl, b, br);
      return {8'(tl), 8'(t), 8'(tr), 8'(ml), 8'(mr), 8'(bl), 8'(b), 8'(br)};
   endfunction

   function automatic int exp_pix(input logic [63:0] w, input int md, input int th,
                                  input int r, input int c);
      int p[8];
      int gx, gy, s, ax, ay;
      for (int k = 0; k < 8; k++) p[k] = int'(w[63-8*k -: 8]);
      if (r == 0 || r == NR-1 || c == 0 || c == NC-1) return 0;
      gx = -p[0] + p[2] - 2*p[3] + 2*p[4] - p[5] + p[7];
      gy = -p[0] - 2*p[1] - p[2] + p[5] + 2*p[6] + p[7];
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      s  = (ax + ay > 255) ? 255 : ax + ay;
      case (md)
         0:       return s;
         1:       return (s >= th) ? 255 : 0;
         2:       return (ax > 255) ? 255 : ax;
         default: return (ay > 255) ? 255 : ay;
      endcase
   endfunction

   // Called #1 after a rising edge; returns #1 after the accepting edge.
   task automatic send(input logic [63:0] w, input logic sof,
                       input int md, input int th);
      logic rdy;
      int   ac;
      exp_t e;
      rdy = 1'b0;
      ac  = 0;
      in_valid  = 1'b1;
      in_sof    = sof;
      window    = w;
      mode      = 2'(md);
      threshold = 8'(th);
      for (int n = 0; n < 50 && !rdy; n++) begin
         @(negedge clk);
         rdy = in_ready;
         ac  = cyc;
         @(posedge clk);
      end
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      if (!rdy) begin
         check("accept_timeout", int'(rdy), 1);
         return;
      end
      if (first_acc < 0) first_acc = ac;
      if (sof) begin
         if (m_row != 0 || m_col != 0) err_at = ac + 1;
         m_row  = 0;
         m_col  = 0;
         m_mode = md;
         m_thr  = th;
      end
      e.pix = exp_pix(w, m_mode, m_thr, m_row, m_col);
      e.sof = int'(m_row == 0 && m_col == 0);
      e.eof = int'(m_row == NR-1 && m_col == NC-1);
      sbq.push_back(e);
      if (m_col == NC-1) begin
         m_col = 0;
         m_row = (m_row == NR-1) ? 0 : m_row + 1;
      end else begin
         m_col++;
      end
   endtask

   task automatic drain();
      for (int n = 0; n < 100 && sbq.size() != 0; n++) @(posedge clk);
      #1;
      check("drain_empty", sbq.size(), 0);
   endtask

   // Output monitor: scoreboard pop, hold checks under stall, sof_err pulse.
   bit       stall_prev = 1'b0;
   bit       lat_done = 1'b0;
   bit [7:0] hold_pix = '0;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         check("sof_err", int'(sof_err), int'(cyc == err_at));
         if (!lat_done && out_valid && first_acc >= 0) begin
            check("latency", cyc - first_acc, 3);
            lat_done = 1'b1;
         end
         if (stall_prev) check("hold_pixel", int'(out_pixel), int'(hold_pix));
         if (out_valid && !out_ready) check("bp_in_ready", int'(in_ready), 0);
         stall_prev = out_valid && !out_ready;
         hold_pix   = out_pixel;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               check("sb_nonempty", sbq.size(), 1);
            end else begin
               e = sbq.pop_front();
               check("pixel", int'(out_pixel), e.pix);
               check("out_sof", int'(out_sof), e.sof);
               check("out_eof", int'(out_eof), e.eof);
            end
         end
      end
   end

   int          cfg_md[6] = '{0, 1, 3, 2, 1, 1};
   int          cfg_th[6] = '{0, 128, 0, 0, 61, 60};
   logic [63:0] win_a, win_b, w;

   initial begin
      win_a     = mkwin(0, 0, 255, 0, 255, 0, 0, 255);
      win_b     = mkwin(0, 10, 0, 0, 0, 0, 40, 0);
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      window    = '0;
      mode      = '0;
      threshold = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_pixel", int'(out_pixel), 0);
      check("rst_out_sof", int'(out_sof), 0);
      check("rst_out_eof", int'(out_eof), 0);
      check("rst_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;

      // Uniform frame: flat image gives zero everywhere.
      for (int i = 0; i < NR*NC; i++)
         send({8{8'd100}}, i == 0, 0, 0);

      // Frames per mode, with a stall in the second one.
      for (int f = 0; f < 6; f++) begin
         fork
            begin
               for (int i = 0; i < NR*NC; i++) begin
                  if (i % 4 == 0)      w = win_a;
                  else if (i % 4 == 1) w = win_b;
                  else                 w = {$urandom, $urandom};
                  if (i == 0) send(w, 1'b1, cfg_md[f], cfg_th[f]);
                  else        send(w, 1'b0, $urandom_range(0, 3), $urandom_range(0, 255));
               end
            end
            begin
               if (f == 1) begin
                  repeat (30) @(posedge clk);
                  #1 out_ready = 1'b0;
                  repeat (5) @(posedge clk);
                  #1 out_ready = 1'b1;
               end
            end
         join
      end

      // Unexpected frame start at (5,17).
      send(win_a, 1'b1, 0, 0);
      for (int i = 1; i < 5*NC + 17; i++) send(win_a, 1'b0, 0, 0);
      send(win_a, 1'b1, 0, 0);
      for (int i = 0; i < NC + 4; i++) send(i % 2 ? win_b : win_a, 1'b0, 2, 0);
      drain();

      // Reset with three windows in flight.
      for (int i = 0; i < 3; i++) send(win_a, 1'b0, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sbq.delete();
      m_row  = 0;
      m_col  = 0;
      m_mode = 1;
      m_thr  = 128;
      @(negedge clk);
      check("rst2_out_valid", int'(out_valid), 0);
      check("rst2_out_pixel", int'(out_pixel), 0);
      check("rst2_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      for (int i = 0; i < NC + 6; i++)
         send(i % 2 ? mkwin(0, 10, 0, 0, 0, 0, 130, 0) : mkwin(0, 10, 0, 0, 0, 0, 70, 0),
              1'b0, 0, 0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sobel_stream.md
# sobel_stream

Streaming, parametrised Sobel edge filter: successor to the single-pixel `sobel_blackBorder`. It accepts one 3×3 neighbourhood per cycle over a valid/ready handshake and tracks the image position with internal row/column counters. Each pixel goes through a 3-stage pipeline that produces a saturated |gx|+|gy| magnitude in one of four output modes. It sits between the line-buffer window generator and the frame writer, and forces border pixels to a fixed value.

## Interface
- `PIX_W`, 8, pixel width in bits.
- `MAX_ROW`, 480, image height in pixels.
- `MAX_COL`, 640, image width in pixels.
- `BORDER_VAL`, 0, output value for border pixels.
- `clk` input 1: pixel clock; all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: window valid.
- `in_ready` output 1: block accepts a window this cycle.
- `in_sof` input 1: window is pixel (0,0) of a new frame.
- `window` input 8*PIX_W: {top_left, top, top_right, mid_left, mid_right, bot_left, bot, bot_right}; top_left is the MSB field. The centre pixel is not used.
- `mode` input 2: 0 = magnitude, 1 = binary threshold, 2 = |gx|, 3 = |gy|.
- `threshold` input PIX_W: binary threshold.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_pixel` output PIX_W: filtered pixel.
- `out_sof` output 1: result is pixel (0,0).
- `out_eof` output 1: result is pixel (MAX_ROW-1, MAX_COL-1).
- `sof_err` output 1: one-cycle pulse when `in_sof` is accepted while the position is not (0,0).

## Operation
- Accept: a window is taken when `in_valid && in_ready`.
- Advance signal: `adv = out_ready || !out_valid`; `in_ready = adv`.
  - All three stages shift together when `adv` is high.
  - Bubbles are not squeezed out.
- Position counters `row` and `col`:
  - An accepted window uses the current (row, col), or (0,0) if `in_sof` is high.
  - The counters then increment col.
  - When col = MAX_COL-1: col wraps to 0 and row increments.
  - When at (MAX_ROW-1, MAX_COL-1): both wrap to (0,0).
- `sof_err`: asserted the cycle after an `in_sof` accept that occurs when the counters are not at (0,0). The counters are still reset to (0,0).
- Frame configuration:
  - `mode` and `threshold` are captured into config registers on an `in_sof` accept, and that capture applies to the sof pixel itself.
  - Both are held for the whole frame; mid-frame changes on the ports are ignored.
- Stage 1 (signed, width PIX_W+3), with window pixels TL, T, TR, ML, MR, BL, B, BR:
  - gx = -TL + TR - 2ML + 2MR - BL + BR
  - gy = -TL - 2T - TR + BL + 2B + BR
  - The border flag, sof/eof flags and config are also registered here.
- Stage 2 (unsigned, width PIX_W+3): registers |gx|, |gy| and their sum. No overflow is possible: the sum is at most 8·(2^PIX_W−1).
- Stage 3 registers `out_pixel`. Let SAT(x) = min(x, 2^PIX_W−1).
  - Border pixel (row 0, row MAX_ROW-1, col 0 or col MAX_COL-1): BORDER_VAL, whatever the mode.
  - Mode 0: SAT(|gx|+|gy|).
  - Mode 1: all-ones if SAT(|gx|+|gy|) ≥ threshold, else 0.
  - Mode 2: SAT(|gx|).
  - Mode 3: SAT(|gy|).
- `out_sof` and `out_eof` are qualified by `out_valid`.

## Timing
- Latency: 3 cycles from accept to `out_valid` when `adv` stays high. Throughput: 1 pixel per cycle.
- Backpressure:
  - While `out_valid && !out_ready`, all stage registers and outputs hold and `in_ready` is 0.
  - Outputs change only on a cycle where `adv` is high.
- Reset (synchronous) values:
  - All stage valids, `out_valid`, `out_sof`, `out_eof`, `sof_err` = 0; `out_pixel` = 0.
  - `in_ready` = 1 the cycle after reset, since the pipeline is empty.
  - row = col = 0.
  - Config registers: mode = 1, threshold = 2^(PIX_W−1).
- Reset asserted mid-frame: in-flight results are discarded and no `out_valid` appears for them. The next accepted window is treated as (0,0) even without `in_sof`.
- An `in_sof` accept on the same cycle as the counter wrap is a normal frame start, not an error.
- A `reset` and `in_valid` on the same edge: the window is not accepted.

## Test plan
- Reset, mode 0 (sof pixel), stream a full 640×480 frame of uniform 100 windows, `out_ready`=1 → every output is 0; `out_sof` on the first result, `out_eof` on the 307200th result, first `out_valid` 3 cycles after the first accept.
- Interior pixel, window TL=ML=BL=0 and TR=MR=BR=255, others 0:
  - mode 0 → 255 (gx=1020, saturated).
  - mode 1, threshold 128 → 255.
  - mode 3 → 0.
  - Same window at col 0 → BORDER_VAL (0).
- Window with T=10, B=40, all other pixels 0; mode 0 → 60; mode 1, threshold 61 → 0; mode 1, threshold 60 → 255.
- Backpressure: drop `out_ready` for 5 cycles mid-stream → `in_ready`=0 and `out_pixel` stable throughout; no pixel lost or duplicated; position tags stay correct.
- Assert `in_sof` at (5,17) → `sof_err` pulses for one cycle; the next output carries `out_sof` and border value 0; the following row/column sequence restarts from (0,1).
- Assert reset with 3 pixels in flight → no `out_valid` on the next cycle; outputs read 0; config reads mode 1 and threshold 128.
